// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache between the fetch stage and a
// word-wide backing memory. Hits answer one cycle after the request; misses
// refill the whole line and return the requested (critical) word.
//
// Optional build feature: define ICACHE_PERF_EN to get saturating hit/miss
// counters; without it hit_count/miss_count are tied to zero.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | waiting for a fetch; req_ready high once out of reset
// S_LOOKUP   | tag/data RAM outputs valid; hit answers, miss starts refill
// S_MISS_REQ | line request presented to backing memory until accepted
// S_REFILL   | collecting LINE_WORDS beats, word 0 first, gaps allowed
// S_RESP     | one-cycle response carrying the captured critical word
module icache_dm #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-3:0] req_index,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
    localparam int RAM_AW = IDX_W + OFF_W;

    localparam logic [31:0]      NOP_INSN  = 32'h0000_0013;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_REFILL,
        S_RESP
    } state_e;

    state_e               state_q, state_d;
    logic [TAG_W-1:0]     req_tag_q, req_tag_d;
    logic [IDX_W-1:0]     req_idx_q, req_idx_d;
    logic [OFF_W-1:0]     req_off_q, req_off_d;
    logic [OFF_W-1:0]     beat_q, beat_d;
    logic [31:0]          crit_q, crit_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic                 live_q;

    logic [31:0]          data_mem [NUM_LINES*LINE_WORDS];
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [31:0]          rd_data_q;
    logic [TAG_W-1:0]     rd_tag_q;

    logic [TAG_W-1:0]     in_tag;
    logic [IDX_W-1:0]     in_idx;
    logic [OFF_W-1:0]     in_off;
    logic [RAM_AW-1:0]    rd_addr;
    logic [RAM_AW-1:0]    wr_addr;
    logic                 lookup_hit;
    logic                 req_hs;
    logic                 data_we;
    logic                 tag_we;

    assign in_off  = req_index[OFF_W-1:0];
    assign in_idx  = req_index[OFF_W +: IDX_W];
    assign in_tag  = req_index[ADDR_W-3 -: TAG_W];
    assign rd_addr = {in_idx, in_off};
    assign wr_addr = {req_idx_q, beat_q};

    // Hit uses the valid bits as they stand this cycle, so a simultaneous
    // flush only affects later lookups.
    assign lookup_hit = (state_q == S_LOOKUP) && valid_q[req_idx_q]
                        && (rd_tag_q == req_tag_q);

    // live_q keeps req_ready low while reset is applied.
    assign req_ready = live_q && ((state_q == S_IDLE) || lookup_hit);
    assign req_hs    = req_valid && req_ready;

    assign resp_valid    = lookup_hit || (state_q == S_RESP);
    assign resp_data     = lookup_hit ? rd_data_q :
                           (state_q == S_RESP) ? crit_q : NOP_INSN;
    assign mem_req_valid = (state_q == S_MISS_REQ);
    assign mem_req_addr  = (state_q == S_MISS_REQ) ?
                           {req_tag_q, req_idx_q, {OFF_W{1'b0}}, 2'b00} : '0;

    // Next-state logic: request capture, refill sequencing and valid bits.
    always_comb begin
        state_d      = state_q;
        req_tag_d    = req_tag_q;
        req_idx_d    = req_idx_q;
        req_off_d    = req_off_q;
        beat_d       = beat_q;
        crit_d       = crit_q;
        flush_pend_d = flush_pend_q;
        valid_d      = valid_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;

        if (req_hs) begin
            req_tag_d = in_tag;
            req_idx_d = in_idx;
            req_off_d = in_off;
        end

        case (state_q)
            S_IDLE: begin
                if (req_hs) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lookup_hit) begin
                    state_d = req_hs ? S_LOOKUP : S_IDLE;
                end else begin
                    state_d = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_REFILL;
                    beat_d  = '0;
                end
            end
            S_REFILL: begin
                if (mem_rvalid) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + OFF_W'(1);
                    if (beat_q == req_off_q) begin
                        crit_d = mem_rdata;
                    end
                    if (beat_q == LAST_BEAT) begin
                        tag_we  = 1'b1;
                        state_d = S_RESP;
                        if (!flush && !flush_pend_q) begin
                            valid_d[req_idx_q] = 1'b1;
                        end
                    end
                end
            end
            S_RESP: begin
                flush_pend_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush while a refill is outstanding must keep that line invalid
        // when it lands, so it is remembered until the response.
        if (flush) begin
            valid_d = '0;
            if ((state_q == S_MISS_REQ) || (state_q == S_REFILL)) begin
                flush_pend_d = 1'b1;
            end
        end
    end

    // Control and valid-bit registers; reset abandons any refill in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            req_tag_q    <= '0;
            req_idx_q    <= '0;
            req_off_q    <= '0;
            beat_q       <= '0;
            crit_q       <= NOP_INSN;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            live_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_tag_q    <= req_tag_d;
            req_idx_q    <= req_idx_d;
            req_off_q    <= req_off_d;
            beat_q       <= beat_d;
            crit_q       <= crit_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            live_q       <= 1'b1;
        end
    end

    // Data RAM: refill write port, synchronous read on request handshake.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[wr_addr] <= mem_rdata;
        end
        if (req_hs) begin
            rd_data_q <= data_mem[rd_addr];
        end
    end

    // Tag RAM: written on the final refill beat, read on request handshake.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[req_idx_q] <= req_tag_q;
        end
        if (req_hs) begin
            rd_tag_q <= tag_mem[in_idx];
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic        lookup_miss;

    assign lookup_miss = (state_q == S_LOOKUP) && !lookup_hit;

    // Saturating hit/miss counters; only reset clears them, not flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (lookup_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (lookup_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
